// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead helper for the pipelined CLA adder.
// The stage register is sized for the widest supported operand; unused upper bits stay zero.
package cla_pkg;

   localparam int CLA_MAX_W     = 64;
   localparam int CLA_MAX_GROUP = 16;

   typedef struct packed {
      logic                 valid;
      logic                 sub;
      logic [CLA_MAX_W-1:0] x_rem;
      logic [CLA_MAX_W-1:0] y_rem;
      logic [CLA_MAX_W-1:0] sum_acc;
      logic                 carry;
   } cla_stage_t;

   function automatic logic [CLA_MAX_GROUP:0] cla_carries(
      input logic [CLA_MAX_GROUP-1:0] g,
      input logic [CLA_MAX_GROUP-1:0] p,
      input logic                     cin
   );
      logic [CLA_MAX_GROUP:0] c;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < CLA_MAX_GROUP; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_group_unit.sv
// Combinational GROUP-bit carry-lookahead slice: generate/propagate, group carries, sum bits.
module cla_group_unit
   import cla_pkg::*;
#(
   parameter int GROUP = 3
) (
   input  logic [GROUP-1:0] x,
   input  logic [GROUP-1:0] y,
   input  logic             cin,
   output logic [GROUP-1:0] s,
   output logic             cout
);

   logic [CLA_MAX_GROUP-1:0] g_s;
   logic [CLA_MAX_GROUP-1:0] p_s;
   logic [CLA_MAX_GROUP:0]   c_s;

   // generate/propagate, lookahead carries and sum for this group
   always_comb begin
      g_s            = '0;
      p_s            = '0;
      g_s[GROUP-1:0] = x & y;
      p_s[GROUP-1:0] = x ^ y;
      c_s            = cla_carries(g_s, p_s, cin);
      s              = p_s[GROUP-1:0] ^ c_s[GROUP-1:0];
      cout           = c_s[GROUP];
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, GPS groups of GROUP bits resolved per stage.
// Optional signed-overflow output enabled by defining CLA_OVF_EN.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int GROUP = 3,
   parameter int GPS   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SW     = (GROUP * GPS < 1) ? 1 : GROUP * GPS;
   localparam int NSTAGE = WIDTH / SW;
   localparam int LAST   = NSTAGE - 1;

   if ((GROUP < 1) || (GPS < 1) || ((WIDTH % SW) != 0) ||
       (WIDTH > CLA_MAX_W) || (GROUP > CLA_MAX_GROUP)) begin : g_cfg_err
      $error("pipelined_cla_adder: unsupported WIDTH/GROUP/GPS combination");
   end

   logic             advance_s;
   logic [WIDTH-1:0] y_eff_s;
   cla_stage_t       head_s;

   // A single global enable: the whole pipe moves unless a held result is blocked
   assign advance_s = out_ready | ~out_valid;
   assign in_ready  = advance_s;

   // operand beat as seen by the first stage, subtraction folded into y and carry-in
   always_comb begin
      y_eff_s                = sub ? ~y : y;
      head_s                 = '0;
      head_s.valid           = in_valid;
      head_s.sub             = sub;
      head_s.x_rem[WIDTH-1:0] = x;
      head_s.y_rem[WIDTH-1:0] = y_eff_s;
      head_s.carry           = sub ? 1'b1 : cin;
   end

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      cla_stage_t  src_s;
      cla_stage_t  nxt_s;
      cla_stage_t  stage_r;
      logic [SW-1:0] src_x_s;
      logic [SW-1:0] src_y_s;
      logic [SW-1:0] ssum_s;
      logic [GPS:0]  gc_s;

      if (k == 0) begin : g_src_head
         assign src_s = head_s;
      end else begin : g_src_prev
         assign src_s = g_stage[k-1].stage_r;
      end

      assign src_x_s = src_s.x_rem[SW-1:0];
      assign src_y_s = src_s.y_rem[SW-1:0];
      assign gc_s[0] = src_s.carry;

      for (genvar j = 0; j < GPS; j++) begin : g_grp
         cla_group_unit #(.GROUP(GROUP)) u_grp (
            .x    (src_x_s[j*GROUP +: GROUP]),
            .y    (src_y_s[j*GROUP +: GROUP]),
            .cin  (gc_s[j]),
            .s    (ssum_s[j*GROUP +: GROUP]),
            .cout (gc_s[j+1])
         );
      end

      // consume this stage's operand slice and deposit its sum bits at their final position
      always_comb begin
         nxt_s         = src_s;
         nxt_s.x_rem   = src_s.x_rem >> SW;
         nxt_s.y_rem   = src_s.y_rem >> SW;
         nxt_s.sum_acc = src_s.sum_acc | (CLA_MAX_W'(ssum_s) << (k * SW));
         nxt_s.carry   = gc_s[GPS];
      end

      // stage register; holds everything, valid included, while the pipe is stalled
      always_ff @(posedge clk) begin
         if (rst) begin
            stage_r <= '0;
         end else if (advance_s) begin
            stage_r <= nxt_s;
         end else begin
            stage_r <= stage_r;
         end
      end
   end

   assign out_valid = g_stage[LAST].stage_r.valid;
   assign sum       = g_stage[LAST].stage_r.sum_acc[WIDTH-1:0];
   assign cout      = g_stage[LAST].stage_r.carry;

`ifdef CLA_OVF_EN
   logic ovf_r;
   logic ovf_nxt_s;

   // carry into the MSB recovered as x ^ y ^ s at that bit, then compared with the carry out
   assign ovf_nxt_s = g_stage[LAST].src_x_s[SW-1] ^ g_stage[LAST].src_y_s[SW-1] ^
                      g_stage[LAST].ssum_s[SW-1]  ^ g_stage[LAST].gc_s[GPS];

   // overflow flag travels with the final stage register
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (advance_s) begin
         ovf_r <= ovf_nxt_s;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder (WIDTH=12, GROUP=3, GPS=1, 4-cycle latency).
// Checks ovf only when CLA_OVF_EN is defined.
module tb_pipelined_cla_adder;

   localparam int WIDTH  = 12;
   localparam int NSTAGE = 4;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             cin       = 1'b0;
   logic             sub       = 1'b0;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] x         = 12'h000;
   logic [WIDTH-1:0] y         = 12'h000;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [13:0] exp_q[$];
   logic [13:0] mon_e;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(3), .GPS(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

`ifndef CLA_OVF_EN
   assign ovf = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // scoreboard: every handshaken result must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_out", out_valid, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("out_sum", sum, mon_e[11:0]);
            check_val("out_cout", cout, mon_e[12]);
`ifdef CLA_OVF_EN
            check_val("out_ovf", ovf, mon_e[13]);
`endif
         end
      end
   end

   task automatic send(input logic [11:0] xv, input logic [11:0] yv, input logic cv, input logic sv,
                       input logic [11:0] es, input logic ec, input logic eo, input bit push);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      x        = xv;
      y        = yv;
      cin      = cv;
      sub      = sv;
      if (push) exp_q.push_back({eo, ec, es});
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, exp_q.size(), 0);
   endtask

   logic [11:0] t3_x[4] = '{12'h001, 12'h002, 12'h003, 12'h004};
   logic [11:0] t3_s[4] = '{12'h012, 12'h013, 12'h014, 12'h015};

   // x, y, cin, sub, expected sum, cout, ovf
   logic [11:0] t5_x[6]  = '{12'h005, 12'h00A, 12'h800, 12'h7FF, 12'hFFF, 12'h800};
   logic [11:0] t5_y[6]  = '{12'h007, 12'h003, 12'h001, 12'h001, 12'hFFF, 12'h800};
   logic        t5_c[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic        t5_sb[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [11:0] t5_s[6]  = '{12'hFFE, 12'h007, 12'h7FF, 12'h800, 12'hFFF, 12'h000};
   logic        t5_co[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic        t5_ov[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_sum", sum, 12'h000);
      check_val("rst_cout", cout, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b1);
`ifdef CLA_OVF_EN
      check_val("rst_ovf", ovf, 1'b0);
`endif

      // single beat, latency
      send(12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1);
      idle();
      for (int i = 1; i <= NSTAGE; i++) begin
         @(negedge clk);
         check_val("lat_valid", out_valid, (i == NSTAGE));
      end
      check_val("lat_sum", sum, 12'h000);
      check_val("lat_cout", cout, 1'b1);
      drain("lat_drain");

      // back-to-back
      for (int i = 0; i < 4; i++) begin
         send(t3_x[i], 12'h010, 1'b1, 1'b0, t3_s[i], 1'b0, 1'b0, 1'b1);
      end
      idle();
      drain("b2b_drain");

      // backpressure
      out_ready = 1'b0;
      send(12'h100, 12'h001, 1'b0, 1'b0, 12'h101, 1'b0, 1'b0, 1'b1);
      send(12'h200, 12'h001, 1'b0, 1'b0, 12'h201, 1'b0, 1'b0, 1'b1);
      send(12'h300, 12'h001, 1'b0, 1'b0, 12'h301, 1'b0, 1'b0, 1'b1);
      idle();
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("bp_reach_valid", out_valid, 1'b1);
      in_valid = 1'b1;
      x        = 12'h400;
      y        = 12'h001;
      cin      = 1'b0;
      sub      = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("bp_in_ready", in_ready, 1'b0);
         check_val("bp_out_valid", out_valid, 1'b1);
         check_val("bp_sum_hold", sum, 12'h101);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 12'h401});
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain("bp_drain");

      // subtraction, carry and overflow boundaries
      for (int i = 0; i < 6; i++) begin
         send(t5_x[i], t5_y[i], t5_c[i], t5_sb[i], t5_s[i], t5_co[i], t5_ov[i], 1'b1);
      end
      idle();
      drain("arith_drain");

      // reset while three beats are in flight
      send(12'h0AA, 12'h011, 1'b0, 1'b0, 12'h0BB, 1'b0, 1'b0, 1'b0);
      send(12'h0AB, 12'h011, 1'b0, 1'b0, 12'h0BC, 1'b0, 1'b0, 1'b0);
      send(12'h0AC, 12'h011, 1'b0, 1'b0, 12'h0BD, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("mid_rst_valid", out_valid, 1'b0);
      check_val("mid_rst_sum", sum, 12'h000);
      check_val("mid_rst_cout", cout, 1'b0);
      check_val("mid_rst_in_ready", in_ready, 1'b1);
      repeat (8) begin
         @(negedge clk);
         check_val("mid_rst_quiet", out_valid, 1'b0);
      end
      check_val("final_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
